stride_seq: RTL

- Command sequencer directly upstream of the address generator.
- Accepts a strided-transfer command (base, stride, beat count) over a valid/ready handshake. Drives the address generator's en/load_base/base_addr/stride controls.
- Issues one request per beat to the memory side, using a valid/ready handshake.
- The request address is the address generator's registered output. This block owns only sequencing, beat counting and completion.

---
 rtl/stride_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/stride_seq.sv
// Strided-transfer command sequencer: accepts a command, steers the address generator, issues one request per beat.
// Optional request stall counter enabled by defining STRIDE_SEQ_STALL_CNT_EN.
module stride_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  abort,
    output logic                  ag_en,
    output logic                  ag_load_base,
    output logic [ADDR_WIDTH-1:0] ag_base_addr,
    output logic [ADDR_WIDTH-1:0] ag_stride,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  req_last,
    output logic [LEN_WIDTH-1:0]  beat_cnt,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            stride_q <= '0;
            len_q    <= '0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stride_d     = stride_q;
        len_d        = len_q;
        beat_d       = beat_q;
        cmd_ready    = 1'b0;
        ag_en        = 1'b0;
        ag_load_base = 1'b0;
        ag_base_addr = '0;
        req_valid    = 1'b0;
        req_last     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // Load the generator now so its output is cmd_base on the first ISSUE cycle.
                    ag_load_base = 1'b1;
                    ag_en        = 1'b1;
                    ag_base_addr = cmd_base;
                    stride_d     = cmd_stride;
                    len_d        = cmd_len;
                    beat_d       = '0;
                    state_d      = (cmd_len != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                req_valid = 1'b1;
                req_last  = (beat_q == len_q - LEN_WIDTH'(1));
                // Abort wins over a same-cycle handshake: that beat is dropped.
                if (abort) begin
                    state_d = DONE;
                end else if (req_ready) begin
                    ag_en  = 1'b1;
                    beat_d = beat_q + LEN_WIDTH'(1);
                    if (req_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ag_stride = stride_q;
    assign beat_cnt  = beat_q;

`ifdef STRIDE_SEQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (state_q == IDLE && cmd_valid) begin
            stall_d = '0;
        end else if (state_q == ISSUE && !req_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
